// File: rtl/sipo_rr_arbiter_if.sv
// Bundle between serial sources, the shared deserializer and the parallel consumer.
// The arbiter takes the slave view; whoever drives sources and the consumer takes master.
interface sipo_rr_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]  req_in;
    logic [NREQ-1:0]  data_in;
    logic [NREQ-1:0]  valid_in;
    logic [NREQ-1:0]  ready_out;
    logic [NREQ-1:0]  grant_out;
    logic [WIDTH-1:0] data_out;
    logic [IDW-1:0]   id_out;
    logic             valid_out;
    logic             ready_in;

    modport slave (
        input  req_in, data_in, valid_in, ready_in,
        output ready_out, grant_out, data_out, id_out, valid_out
    );

    modport master (
        output req_in, data_in, valid_in, ready_in,
        input  ready_out, grant_out, data_out, id_out, valid_out
    );
endinterface

// File: rtl/sipo_rr_arbiter.sv
// Round-robin owner of one shared serial-to-parallel deserializer: grants a source
// for a whole word, shifts it in MSB-first, then hands it off with the source index.
module sipo_rr_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input logic              clk_in,
    input logic              rst_n,
    sipo_rr_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   gidx;
    logic [IDW-1:0]   last;
    logic [IDW-1:0]   win_idx;
    logic             win_vld;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] word_nxt;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] data_q;
    logic [IDW-1:0]   id_q;
    logic             valid_q;
    logic [NREQ-1:0]  ready;
    logic             bit_in;
    logic             bit_acc;
    logic             word_done;
    logic             handoff;

    // Scan from farthest to nearest after ptr so the nearest requester overwrites.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] req,
                                             input logic [IDW-1:0]  ptr);
        logic [IDW:0] pick;
        int           idx;
        pick = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = (int'(ptr) + i) % NREQ;
            if (req[IDW'(idx)]) pick = {1'b1, IDW'(idx)};
        end
        return pick;
    endfunction

    assign {win_vld, win_idx} = rr_pick(bus.req_in, last);
    assign bit_in    = bus.data_in[gidx];
    assign bit_acc   = bus.valid_in[gidx] && ready[gidx];
    assign word_done = bit_acc && (count == CW'(WIDTH - 1));
    assign word_nxt  = {shift_reg[WIDTH-2:0], bit_in};
    assign handoff   = valid_q && bus.ready_in;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld)   state_nxt = SHIFT;
            SHIFT:   if (word_done) state_nxt = HOLD;
            HOLD:    if (handoff)   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = '0;
        if (state == SHIFT) ready = grant;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            grant     <= '0;
            gidx      <= '0;
            last      <= IDW'(NREQ - 1);
            shift_reg <= '0;
            count     <= '0;
            data_q    <= '0;
            id_q      <= '0;
            valid_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant     <= NREQ'(1) << win_idx;
                        gidx      <= win_idx;
                        shift_reg <= '0;
                        count     <= '0;
                    end else begin
                        grant <= '0;
                    end
                end
                SHIFT: begin
                    if (bit_acc) begin
                        shift_reg <= word_nxt;
                        count     <= count + CW'(1);
                    end
                    if (word_done) begin
                        data_q  <= word_nxt;
                        id_q    <= gidx;
                        valid_q <= 1'b1;
                        grant   <= '0;
                        last    <= gidx;
                    end
                end
                HOLD: begin
                    if (handoff) valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_out = ready;
    assign bus.grant_out = grant;
    assign bus.data_out  = data_q;
    assign bus.id_out    = id_q;
    assign bus.valid_out = valid_q;
endmodule

// File: tb/tb_sipo_rr_arbiter.sv
// Directed bench for sipo_rr_arbiter: expected words queue up as stimulus is issued and
// an independent monitor retires them at each downstream handshake.
module tb_sipo_rr_arbiter;
    localparam int WIDTH = 4;
    localparam int NREQ  = 4;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_in = ~clk_in;

    sipo_rr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    sipo_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    int         total = 0;
    int         bad   = 0;
    logic [5:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, bus.grant_out, 0);
        check({tag, "_ready"}, bus.ready_out, 0);
        check({tag, "_valid"}, bus.valid_out, 0);
        check({tag, "_data"},  bus.data_out,  0);
        check({tag, "_id"},    bus.id_out,    0);
    endtask

    // Retire one expected word per downstream handshake.
    always @(negedge clk_in) begin
        logic [5:0] e;
        if (rst_n && bus.valid_out && bus.ready_in) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got id=%0d data=%b required none", bus.id_out, bus.data_out);
            end else begin
                e = sb.pop_front();
                check("word_id",   bus.id_out,   e[5:4]);
                check("word_data", bus.data_out, e[3:0]);
            end
        end
    end

    // Called at a negedge; presents bits MSB-first and moves on once each is accepted.
    task automatic feed(input int s, input logic [3:0] w, input int stall_at, input int stall_len);
        int t;
        for (int b = 0; b < WIDTH; b++) begin
            if (b == stall_at) begin
                bus.valid_in[s] = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk_in);
                    check("stall_ready_held", bus.ready_out[s], 1);
                end
            end
            bus.data_in[s]  = w[WIDTH-1-b];
            bus.valid_in[s] = 1'b1;
            t = 0;
            while (!bus.ready_out[s] && t < 50) begin
                @(negedge clk_in);
                t++;
            end
            if (t >= 50) begin
                total++;
                bad++;
                $display("FAIL feed_timeout: src=%0d got ready=0 required 1", s);
            end
            @(negedge clk_in);
        end
        bus.valid_in[s] = 1'b0;
    endtask

    task automatic wait_grant(input string name);
        int t;
        t = 0;
        while (bus.grant_out == 0 && t < 50) begin
            @(negedge clk_in);
            t++;
        end
        if (t >= 50) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got grant=0 required nonzero", name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish required finish before limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         t;
        int         gap;
        int         rdy_cnt;
        logic [1:0] fair_ids[5];
        logic [3:0] src_bits;
        logic [3:0] w;

        fair_ids = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1};
        bus.req_in   = '0;
        bus.data_in  = '0;
        bus.valid_in = '0;
        bus.ready_in = 1'b1;

        #12;
        check_all_zero("rst_hold");
        @(negedge clk_in);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_in);
        check_all_zero("idle_noreq");

        // Fairness: sources 0,1,3 request continuously; each source streams a constant bit.
        src_bits     = 4'b1001;
        bus.data_in  = src_bits;
        bus.valid_in = 4'b1011;
        bus.req_in   = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            gap = 0;
            while (bus.grant_out == 0 && gap < 50) begin
                @(negedge clk_in);
                gap++;
            end
            if (k > 0) check("fair_gap", gap, 2);
            check("fair_grant", bus.grant_out, 4'b0001 << fair_ids[k]);
            sb.push_back({fair_ids[k], {WIDTH{src_bits[fair_ids[k]]}}});
            if (k == 4) bus.req_in = '0;
            t = 0;
            while (bus.grant_out != 0 && t < 50) begin
                @(negedge clk_in);
                t++;
            end
        end
        repeat (3) @(negedge clk_in);
        bus.valid_in = '0;
        bus.data_in  = '0;
        check("fair_idle_grant", bus.grant_out, 0);

        // Single word from source 2.
        w = 4'b1011;
        sb.push_back({2'd2, w});
        bus.req_in      = 4'b0100;
        bus.valid_in[2] = 1'b1;
        bus.data_in[2]  = w[3];
        @(negedge clk_in);
        check("single_grant", bus.grant_out, 4'b0100);
        check("single_ready", bus.ready_out, 4'b0100);
        bus.req_in = '0;
        rdy_cnt = 0;
        for (int b = 3; b >= 0; b--) begin
            bus.data_in[2] = w[b];
            if (bus.ready_out[2]) rdy_cnt++;
            @(negedge clk_in);
        end
        bus.valid_in[2] = 1'b0;
        check("single_ready_cycles", rdy_cnt, 4);
        check("single_valid", bus.valid_out, 1);
        check("single_data", bus.data_out, w);
        check("single_id", bus.id_out, 2);
        check("single_ready_off", bus.ready_out, 0);
        @(negedge clk_in);
        check("single_valid_drop", bus.valid_out, 0);
        repeat (2) @(negedge clk_in);

        // Stall: source 1 drops valid for 3 cycles between bits 2 and 3.
        w = 4'b0110;
        sb.push_back({2'd1, w});
        bus.req_in = 4'b0010;
        feed(1, w, 2, 3);
        bus.req_in = '0;
        check("stall_valid", bus.valid_out, 1);
        check("stall_data", bus.data_out, w);
        repeat (3) @(negedge clk_in);

        // Backpressure on source 3's word; a new request must not be arbitrated meanwhile.
        @(posedge clk_in);
        #1 bus.ready_in = 1'b0;
        @(negedge clk_in);
        w = 4'b1100;
        sb.push_back({2'd3, w});
        bus.req_in = 4'b1000;
        feed(3, w, -1, 0);
        bus.req_in = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", bus.valid_out, 1);
            check("bp_data",  bus.data_out,  w);
            check("bp_id",    bus.id_out,    3);
            check("bp_ready", bus.ready_out, 0);
            check("bp_grant", bus.grant_out, 0);
            @(negedge clk_in);
        end
        @(posedge clk_in);
        #1;
        bus.ready_in = 1'b1;
        bus.req_in   = '0;
        @(negedge clk_in);
        @(negedge clk_in);
        check("bp_valid_drop", bus.valid_out, 0);
        repeat (2) @(negedge clk_in);

        // Reset in the middle of source 3's word; its two bits must never surface.
        bus.req_in      = 4'b1000;
        bus.valid_in[3] = 1'b1;
        bus.data_in[3]  = 1'b1;
        wait_grant("mid_grant");
        check("mid_grant_src3", bus.grant_out, 4'b1000);
        repeat (2) @(negedge clk_in);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        bus.valid_in = '0;
        bus.data_in  = '0;
        bus.req_in   = '0;
        @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        w = 4'b0101;
        bus.req_in = 4'b1001;
        wait_grant("post_rst_grant");
        check("post_rst_src0", bus.grant_out, 4'b0001);
        bus.req_in = '0;
        sb.push_back({2'd0, w});
        feed(0, w, -1, 0);
        check("post_rst_data", bus.data_out, w);
        check("post_rst_id", bus.id_out, 0);
        repeat (4) @(negedge clk_in);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
